pipe_skid_reg: RTL and testbench

Elastic 32-bit pipeline stage with a valid/ready handshake on both sides and a one-entry skid buffer. It sits between CPU pipeline stages where the downstream consumer can stall, replacing a bare load-enabled register. Upstream gets a registered ready with no combinational path from downstream ready. Full throughput is one word per cycle, with one cycle of latency.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_skid_reg.sv | 79 +++++++
 tb/tb_pipe_skid_reg.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_pkg : shared types and constants for the elastic pipeline stage |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package pipe_pkg;

   localparam int DATA_W = 32;

   // Encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_skid_reg : valid/ready pipeline register with one-entry skid    |
// |                 buffer; in_ready depends only on registered state    |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int WIDTH = DATA_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       count
);

   state_t           r_state;
   logic [WIDTH-1:0] r_main;
   logic [WIDTH-1:0] r_skid;
   logic             w_ia;
   logic             w_oa;

   assign in_ready  = (r_state != ST_FULL);
   assign out_valid = (r_state != ST_EMPTY);
   assign out_data  = r_main;
   assign count     = r_state;

   assign w_ia = in_valid & in_ready;
   assign w_oa = out_valid & out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_EMPTY;
         r_main  <= '0;
         r_skid  <= '0;
      end else if (flush) begin
         // Flush wins over any transfer; a same-cycle output accept is
         // already consumed downstream, an input accept is dropped.
         r_state <= ST_EMPTY;
         r_main  <= '0;
         r_skid  <= '0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_ia) begin
                  r_main  <= in_data;
                  r_state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (w_ia && w_oa) begin
                  r_main <= in_data;
               end else if (w_ia) begin
                  r_skid  <= in_data;
                  r_state <= ST_FULL;
               end else if (w_oa) begin
                  r_state <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (w_oa) begin
                  r_main  <= r_skid;
                  r_state <= ST_BUSY;
               end
            end
            default: r_state <= ST_EMPTY;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_skid_reg : directed and queue-model bench for pipe_skid_reg  |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
module tb_pipe_skid_reg;

   localparam int c_w = 32;

   logic           clk;
   logic           reset;
   logic           flush;
   logic           in_valid;
   logic           in_ready;
   logic [c_w-1:0] in_data;
   logic           out_valid;
   logic           out_ready;
   logic [c_w-1:0] out_data;
   logic [1:0]     count;

   int checks;
   int failures;

   pipe_skid_reg #(.WIDTH(c_w)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h77;
      out_ready = 1'b0;
      tick();
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (count !== 2'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
      reset = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 32'h77) begin failures++; $display("FAIL reset_first_accept got=%b/%h exp=1/00000077", out_valid, out_data); end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      checks++; if (count !== 2'd0) begin failures++; $display("FAIL reset_drain_count got=%0d exp=0", count); end
   endtask

   task automatic test_stream();
      bit saw_stall;
      saw_stall = 1'b0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         in_data = k;
         tick();
         if (in_ready !== 1'b1 || count !== 2'd1) saw_stall = 1'b1;
         checks++; if (out_valid !== 1'b1 || out_data !== 32'(k)) begin failures++; $display("FAIL stream_word%0d got=%b/%h exp=1/%h", k, out_valid, out_data, 32'(k)); end
      end
      checks++; if (saw_stall) begin failures++; $display("FAIL stream_steady got=stalled exp=count1_ready1"); end
      in_valid = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin failures++; $display("FAIL stream_drain got=%b/%0d exp=0/0", out_valid, count); end
   endtask

   task automatic test_full_backpressure();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'hA;
      tick();
      checks++; if (count !== 2'd1 || in_ready !== 1'b1) begin failures++; $display("FAIL full_first got=%0d/%b exp=1/1", count, in_ready); end
      in_data = 32'hB;
      tick();
      checks++; if (count !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA) begin failures++; $display("FAIL full_state got=%0d/%b/%h exp=2/0/0000000a", count, in_ready, out_data); end
      in_data = 32'hC;
      tick();
      checks++; if (count !== 2'd2 || out_data !== 32'hA) begin failures++; $display("FAIL full_hold got=%0d/%h exp=2/0000000a", count, out_data); end
      out_ready = 1'b1;
      tick();
      checks++; if (count !== 2'd1 || in_ready !== 1'b1 || out_data !== 32'hB) begin failures++; $display("FAIL full_drain_b got=%0d/%b/%h exp=1/1/0000000b", count, in_ready, out_data); end
      tick();
      checks++; if (count !== 2'd1 || out_data !== 32'hC) begin failures++; $display("FAIL full_drain_c got=%0d/%h exp=1/0000000c", count, out_data); end
      in_valid = 1'b0;
      tick();
      checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL full_empty got=%0d/%b exp=0/0", count, out_valid); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h1;
      tick();
      in_data = 32'h2;
      tick();
      checks++; if (count !== 2'd2) begin failures++; $display("FAIL flush_prefill got=%0d exp=2", count); end
      flush   = 1'b1;
      in_data = 32'hDEAD;
      tick();
      checks++; if (count !== 2'd0 || out_valid !== 1'b0 || out_data !== 32'h0) begin failures++; $display("FAIL flush_clear got=%0d/%b/%h exp=0/0/0", count, out_valid, out_data); end
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b0 || out_data === 32'hDEAD) begin failures++; $display("FAIL flush_no_dead got=%b/%h exp=0/0", out_valid, out_data); end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h55;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || count !== 2'd1) begin failures++; $display("FAIL areset_busy got=%b/%0d exp=1/1", out_valid, count); end
      #2;
      reset = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || count !== 2'd0 || in_ready !== 1'b1 || out_data !== 32'h0) begin failures++; $display("FAIL areset_immediate got=%b/%0d/%b/%h exp=0/0/1/0", out_valid, count, in_ready, out_data); end
      #1;
      reset     = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin failures++; $display("FAIL areset_after got=%b/%0d exp=0/0", out_valid, count); end
   endtask

   task automatic test_random();
      logic [c_w-1:0] q[$];
      bit ia;
      bit oa;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 99) == 0);
         in_data   = $urandom;
         checks++; if (count !== 2'(q.size())) begin failures++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", cyc, count, q.size()); end
         checks++; if (in_ready !== (q.size() < 2)) begin failures++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, q.size() < 2); end
         checks++; if (out_valid !== (q.size() != 0)) begin failures++; $display("FAIL rand_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, q.size() != 0); end
         if (q.size() != 0) begin
            checks++; if (out_data !== q[0]) begin failures++; $display("FAIL rand_out_data cyc=%0d got=%h exp=%h", cyc, out_data, q[0]); end
         end
         ia = in_valid && (q.size() < 2);
         oa = out_ready && (q.size() != 0);
         tick();
         if (flush) begin
            q.delete();
         end else begin
            if (oa) void'(q.pop_front());
            if (ia) q.push_back(in_data);
         end
      end
      flush    = 1'b0;
      in_valid = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_stream();
      test_full_backpressure();
      test_flush();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
